// File: rtl/ahb_tb_status_slv.sv
// AHB-Lite test-status slave: buffered stdout byte stream, exit code, sticky
// pass/fail flags and a free-running cycle counter behind a small register window.
module ahb_tb_status_slv #(
    parameter int unsigned P_DELAY      = 0,
    parameter int unsigned P_FIFO_DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYin,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout,
    output logic        char_valid_o,
    output logic [7:0]  char_data_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic [31:0] exit_value_o,
    output logic        exit_valid_o
);

    localparam int unsigned AW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StFull,
        StErr1,
        StErr2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic [7:0]      off_q;
    logic            write_q;
    logic [31:0]     cycles_q;
    logic [31:0]     exit_value_q;
    logic            exit_valid_q;
    logic            passed_q;
    logic            failed_q;

    logic [7:0]      fifo_mem [P_FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;

    logic            accept;
    logic            addr_err;
    logic            hready;
    logic [1:0]      hresp;
    logic            done;
    logic            is_stdout, is_exit, is_status, is_cycles;
    logic            stdout_wr;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            push_ok;
    logic [7:0]      wbyte;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign unused_bits = ^{HBURST, HADDR[31:8], HTRANS[0]};

    assign accept = HSEL & HTRANS[1] & HREADYin;

    // Address-phase decode: registers other than STDOUT take aligned word accesses only.
    always_comb begin
        addr_err = 1'b0;
        case (HADDR[7:2])
            6'd0:                addr_err = 1'b0;
            6'd1, 6'd2, 6'd3:    addr_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00);
            default:             addr_err = 1'b1;
        endcase
    end

    assign is_stdout = (off_q[7:2] == 6'd0);
    assign is_exit   = (off_q[7:2] == 6'd1);
    assign is_status = (off_q[7:2] == 6'd2);
    assign is_cycles = (off_q[7:2] == 6'd3);
    assign stdout_wr = write_q && is_stdout;

    assign char_valid_o = (count_q != '0);
    assign char_data_o  = char_valid_o ? fifo_mem[rptr_q] : 8'h00;
    assign fifo_full    = (count_q == CW'(P_FIFO_DEPTH));
    assign pop          = char_valid_o && char_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok      = !fifo_full || pop;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hready  = 1'b1;
        hresp   = 2'b00;
        done    = 1'b0;
        case (state_q)
            StIdle: ;
            StWait: begin
                hready = 1'b0;
                if (wait_q <= 4'd1) begin
                    state_d = StData;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StData: begin
                if (stdout_wr && !push_ok) begin
                    hready  = 1'b0;
                    state_d = StFull;
                end else begin
                    done = 1'b1;
                end
            end
            StFull: begin
                if (push_ok) begin
                    done = 1'b1;
                end else begin
                    hready = 1'b0;
                end
            end
            StErr1: begin
                hready  = 1'b0;
                hresp   = 2'b01;
                state_d = StErr2;
            end
            StErr2: hresp = 2'b01;
            default: state_d = StIdle;
        endcase
        if (hready) begin
            if (accept) begin
                state_d = addr_err ? StErr1 : ((P_DELAY > 0) ? StWait : StData);
                wait_d  = 4'(P_DELAY);
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (off_q[7:2])
            6'd0:    rdata = 32'(count_q);
            6'd1:    rdata = exit_value_q;
            6'd2:    rdata = {29'b0, exit_valid_q, failed_q, passed_q};
            6'd3:    rdata = cycles_q;
            default: rdata = 32'h0;
        endcase
    end

    assign HREADYout = hready;
    assign HRESP     = hresp;
    assign HRDATA    = (done && !write_q) ? rdata : 32'h0;

    assign push  = done && stdout_wr;
    assign wbyte = HWDATA[{off_q[1:0], 3'b000} +: 8];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            off_q   <= 8'h00;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (hready && accept) begin
                off_q   <= HADDR[7:0];
                write_q <= HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cycles_q     <= 32'h0;
            exit_value_q <= 32'h0;
            exit_valid_q <= 1'b0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            cycles_q <= (done && write_q && is_cycles) ? 32'h0 : cycles_q + 32'h1;
            if (done && write_q && is_exit) begin
                exit_value_q <= HWDATA;
                exit_valid_q <= 1'b1;
            end
            if (done && write_q && is_status) begin
                passed_q <= passed_q | HWDATA[0];
                failed_q <= failed_q | HWDATA[1];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) fifo_mem[wptr_q] <= wbyte;
    end

    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_value_o   = exit_value_q;
    assign exit_valid_o   = exit_valid_q;

endmodule

// File: tb/tb_ahb_tb_status_slv.sv
// Directed bench: two instances (zero and three wait states) share one bus and
// are selected individually through their own HSEL.
module tb_ahb_tb_status_slv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic        hsel0, hsel1;

    logic [31:0] hrdata0, hrdata1;
    logic [1:0]  hresp0, hresp1;
    logic        hready0, hready1;
    logic        cv0, cv1;
    logic [7:0]  cd0, cd1;
    logic        cr0, cr1;
    logic        tp0, tp1, tf0, tf1;
    logic [31:0] ev0, ev1;
    logic        evld0, evld1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_tb_status_slv #(.P_DELAY(0), .P_FIFO_DEPTH(8)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYin(hready0), .HRDATA(hrdata0), .HRESP(hresp0), .HREADYout(hready0),
        .char_valid_o(cv0), .char_data_o(cd0), .char_ready_i(cr0),
        .tests_passed_o(tp0), .tests_failed_o(tf0), .exit_value_o(ev0),
        .exit_valid_o(evld0)
    );

    ahb_tb_status_slv #(.P_DELAY(3), .P_FIFO_DEPTH(8)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADYin(hready1), .HRDATA(hrdata1), .HRESP(hresp1), .HREADYout(hready1),
        .char_valid_o(cv1), .char_data_o(cd1), .char_ready_i(cr1),
        .tests_passed_o(tp1), .tests_failed_o(tf1), .exit_value_o(ev1),
        .exit_valid_o(evld1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; called just after a rising edge, returns just after one.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] resp_first,
                        output logic [1:0] resp, output int waits);
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] rd;
        rdy = 1'b0;
        rsp = 2'b00;
        rd  = 32'h0;
        resp_first = 2'b00;
        haddr  = {24'h0, addr};
        hwrite = wr;
        hsize  = size;
        htrans = 2'b10;
        hsel0  = (d == 0);
        hsel1  = (d == 1);
        @(posedge clk); #1;
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = wdata;
        waits  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rdy = (d == 0) ? hready0 : hready1;
            rsp = (d == 0) ? hresp0  : hresp1;
            rd  = (d == 0) ? hrdata0 : hrdata1;
            if (i == 0) resp_first = rsp;
            if (rdy) break;
            waits++;
        end
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $error("FAIL xfer_timeout: observed no HREADYout expected completion within 64");
        end
        rdata = rd;
        resp  = rsp;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, c1, c2;
    logic [1:0]  rf, rs;
    int          w;

    initial begin
        rst_n = 1'b0; haddr = '0; hwdata = '0; htrans = '0; hwrite = 1'b0;
        hsize = 3'b010; hburst = '0; hsel0 = 1'b0; hsel1 = 1'b0; cr0 = 1'b0; cr1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hready", 32'(hready0), 1);
        check("rst_hresp", 32'(hresp0), 0);
        check("rst_hrdata", hrdata0, 0);
        check("rst_char_valid", 32'(cv0), 0);
        check("rst_char_data", 32'(cd0), 0);
        check("rst_flags", {29'b0, evld0, tf0, tp0}, 0);
        check("rst_exit_value", ev0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // EXIT write then read, zero wait states
        xfer(0, 1'b1, 8'h04, 3'b010, 32'hCAFE0001, rd, rf, rs, w);
        check("exit_wr_waits", 32'(w), 0);
        check("exit_wr_resp", 32'(rs), 0);
        check("exit_valid", 32'(evld0), 1);
        check("exit_value", ev0, 32'hCAFE0001);
        xfer(0, 1'b0, 8'h04, 3'b010, 32'h0, rd, rf, rs, w);
        check("exit_rd_data", rd, 32'hCAFE0001);
        check("exit_rd_waits", 32'(w), 0);

        // Byte-lane stdout pushes, then drain
        xfer(0, 1'b1, 8'h00, 3'b000, 32'h00000048, rd, rf, rs, w);
        xfer(0, 1'b1, 8'h01, 3'b000, 32'h00006900, rd, rf, rs, w);
        xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, rf, rs, w);
        check("fifo_count_2", rd, 2);
        check("char_valid_1", 32'(cv0), 1);
        cr0 = 1'b1;
        @(negedge clk);
        check("char_h", 32'(cd0), 32'h48);
        @(negedge clk);
        check("char_i", 32'(cd0), 32'h69);
        check("char_valid_2", 32'(cv0), 1);
        @(negedge clk);
        check("char_drained", 32'(cv0), 0);
        cr0 = 1'b0;
        @(posedge clk); #1;

        // Fill FIFO, ninth write stalls until a pop
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b1, 8'h00, 3'b000, 32'h30 + 32'(i), rd, rf, rs, w);
        end
        check("fill_last_waits", 32'(w), 0);
        xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, rf, rs, w);
        check("fifo_count_8", rd, 8);
        haddr = 32'h0; hwrite = 1'b1; hsize = 3'b000; htrans = 2'b10; hsel0 = 1'b1;
        @(posedge clk); #1;
        hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h38;
        @(negedge clk);
        check("full_hold_1", 32'(hready0), 0);
        @(negedge clk);
        check("full_hold_2", 32'(hready0), 0);
        cr0 = 1'b1;
        #1;
        check("full_release", 32'(hready0), 1);
        @(posedge clk); #1;
        cr0 = 1'b0;
        check("full_done_idle", 32'(hready0), 1);
        xfer(0, 1'b0, 8'h00, 3'b010, 32'h0, rd, rf, rs, w);
        check("fifo_count_still_8", rd, 8);
        check("fifo_head_after_pop", 32'(cd0), 32'h31);
        cr0 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        cr0 = 1'b0;
        check("fifo_empty_after_drain", 32'(cv0), 0);

        // Error responses
        xfer(0, 1'b0, 8'h10, 3'b010, 32'h0, rd, rf, rs, w);
        check("err_rd_first", 32'(rf), 1);
        check("err_rd_last", 32'(rs), 1);
        check("err_rd_waits", 32'(w), 1);
        check("err_rd_data", rd, 0);
        xfer(0, 1'b1, 8'h08, 3'b001, 32'h3, rd, rf, rs, w);
        check("err_hw_first", 32'(rf), 1);
        check("err_hw_last", 32'(rs), 1);
        check("err_hw_flags", {30'b0, tf0, tp0}, 0);
        check("err_exit_kept", ev0, 32'hCAFE0001);

        // Cycle counter
        xfer(0, 1'b0, 8'h0C, 3'b010, 32'h0, c1, rf, rs, w);
        repeat (8) @(posedge clk);
        #1;
        xfer(0, 1'b0, 8'h0C, 3'b010, 32'h0, c2, rf, rs, w);
        check("cycles_delta", c2 - c1, 10);
        xfer(0, 1'b1, 8'h0C, 3'b010, 32'h0, rd, rf, rs, w);
        xfer(0, 1'b0, 8'h0C, 3'b010, 32'h0, rd, rf, rs, w);
        check("cycles_after_clear", rd, 1);

        // Three wait states
        xfer(1, 1'b1, 8'h08, 3'b010, 32'h1, rd, rf, rs, w);
        check("dly_status_waits", 32'(w), 3);
        check("dly_status_resp", 32'(rs), 0);
        check("dly_passed", 32'(tp1), 1);
        check("dly_failed", 32'(tf1), 0);
        xfer(1, 1'b1, 8'h08, 3'b010, 32'h0, rd, rf, rs, w);
        check("dly_passed_sticky", 32'(tp1), 1);
        xfer(1, 1'b0, 8'h08, 3'b010, 32'h0, rd, rf, rs, w);
        check("dly_status_rd", rd, 1);
        xfer(1, 1'b1, 8'h04, 3'b010, 32'h000000AA, rd, rf, rs, w);
        check("dly_exit_waits", 32'(w), 3);
        check("dly_exit_value", ev1, 32'h000000AA);

        // Reset in the middle of an EXIT write's wait states
        haddr = 32'h04; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10; hsel1 = 1'b1;
        @(posedge clk); #1;
        hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h00000055;
        @(negedge clk);
        check("rst_mid_wait", 32'(hready1), 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hready", 32'(hready1), 1);
        check("rst_mid_exit_valid", 32'(evld1), 0);
        check("rst_mid_exit_value", ev1, 0);
        check("rst_mid_passed", 32'(tp1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_write_discarded", 32'(evld1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
